seg_code_sequencer: RTL and testbench
=====================================

SEG_CODE_SEQUENCER -- requirements
Module: seg_code_sequencer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, number of consecutive equal samples required to accept a new step_btn level.
REQ-002 SHALL have parameter TICK_DIV, default 2, number of clock cycles per automatic advance in RUN.
REQ-003 SHALL have port clk_2, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port run_sw, input, 1 bit: level; 1 selects automatic advance.
REQ-006 SHALL have port step_btn, input, 1 bit: raw, bouncing push-button; one accepted press gives one manual advance.
REQ-007 SHALL have port dir_sw, input, 1 bit: 0 counts up, 1 counts down.
REQ-008 SHALL have port load_sw, input, 1 bit: level; 1 forces code to load_val.
REQ-009 SHALL have port load_val, input, 6 bits: preset code.
REQ-010 SHALL have port code, output, 6 bits: current display code (0..41) for the 7-segment decoder.
REQ-011 SHALL have port code_valid, output, 1 bit: 1 when code is stable and usable by the decoder.
REQ-012 SHALL have port wrap, output, 1 bit: single-cycle pulse on a range wrap.

Function
REQ-013 SHALL implement FSM states HOLD, RUN, LOAD, evaluated every cycle with priority load_sw > run_sw.
REQ-014 SHALL transition: any state -> LOAD when load_sw=1; LOAD/HOLD -> RUN when load_sw=0 and run_sw=1; LOAD/RUN -> HOLD when load_sw=0 and run_sw=0.
REQ-015 SHALL keep code within 0..MAX_CODE (41) at all times.
REQ-016 SHALL advance code as follows: up gives 41->0, otherwise +1; down gives 0->41, otherwise -1. dir_sw is sampled in the cycle of the advance.
REQ-017 SHALL assert wrap for exactly the cycle after an advance that wraps; wrap SHALL be 0 otherwise.
REQ-018 SHALL, in LOAD, register code = load_val, clamped to 41 when load_val > 41, every cycle; it SHALL NOT assert wrap.
REQ-019 SHALL drive code_valid=0 in any cycle following a cycle spent in LOAD, and 1 otherwise after reset.
REQ-020 SHALL, in RUN, run a tick counter 0..TICK_DIV-1 and advance once when the counter equals TICK_DIV-1; the counter then returns to 0.
REQ-021 SHALL clear the tick counter in HOLD and LOAD, so the first RUN advance occurs TICK_DIV cycles after entering RUN.
REQ-022 SHALL debounce step_btn by changing the debounced level only after DEBOUNCE_CYCLES consecutive equal samples; any differing sample restarts the count.
REQ-023 SHALL produce one step on each 0->1 edge of the debounced level, and change code on the clock edge after that debounced edge (DEBOUNCE_CYCLES+1 edges after a clean raw rise).
REQ-024 SHALL apply steps only in HOLD; steps detected in RUN or LOAD SHALL be discarded, not queued.
REQ-025 SHALL, for TICK_DIV=1, advance every cycle in RUN.

Reset
REQ-026 SHALL, when rst_n=0 at a rising edge, set code=0, code_valid=0, wrap=0, state=HOLD, tick counter=0, debounced level=0 and debounce count=0.
REQ-027 SHALL let reset asserted mid-operation, including mid-debounce or in LOAD, override all other inputs in that cycle.
REQ-028 SHALL set code_valid=1 on the first edge with rst_n=1, unless load_sw=1.

Structure
REQ-029 SHALL place CODE_W=6, MAX_CODE=41 and the state enum (HOLD, RUN, LOAD) in shared package seg_pkg, which is also used by the 7-segment decoder.
REQ-030 SHALL implement the debouncer and edge detector as sub-module sw_debounce (ports clk_2, rst_n, raw, level, rise).

Verification
REQ-031 SHALL test: reset, HOLD, step_btn held high cleanly for 6 cycles -> code 0->1 exactly on the 5th edge after the raw rise; only one increment.
REQ-032 SHALL test: step_btn toggling 1,0,1,0,1 on consecutive cycles, then low -> no code change, no wrap.
REQ-033 SHALL test: load_val=40, load_sw pulse, run_sw=1, dir_sw=0, TICK_DIV=2 -> code 40, 41, 0 at 2-cycle spacing; wrap high one cycle with code=0; code_valid 0 during load.
REQ-034 SHALL test: load_val=63 -> code=41; then dir_sw=1, one step in HOLD -> 40; load_val=0, one down step -> 41 with wrap pulse.
REQ-035 SHALL test: RUN with a clean step press -> code follows ticks only, with no extra advance.
REQ-036 SHALL test: rst_n=0 for one cycle while code=17 in RUN -> next cycle code=0, code_valid=0, wrap=0, state HOLD.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the code sequencer and 7-segment decoder.
// Holds code width, range limit, FSM states and wrap-aware helpers.
package seg_pkg;

  localparam int CODE_W = 6;
  localparam logic [CODE_W-1:0] MAX_CODE = CODE_W'(41);

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    LOAD = 2'd2
  } seq_state_e;

  // Returns {wrapped, next_code}.
  function automatic logic [CODE_W:0] step_code(
    input logic [CODE_W-1:0] c,
    input logic              down
  );
    logic [CODE_W:0] r;
    if (down) begin
      if (c == '0) r = {1'b1, MAX_CODE};
      else r = {1'b0, c - CODE_W'(1)};
    end else begin
      if (c >= MAX_CODE) r = {1'b1, {CODE_W{1'b0}}};
      else r = {1'b0, c + CODE_W'(1)};
    end
    return r;
  endfunction

  function automatic logic [CODE_W-1:0] clamp_code(
    input logic [CODE_W-1:0] v
  );
    return (v > MAX_CODE) ? MAX_CODE : v;
  endfunction

endpackage

// File: rtl/seg_code_sequencer_if.sv
// Control/status bundle between the switch panel and the sequencer.
// master drives the switches, slave produces the display code.
interface seg_code_sequencer_if;
  import seg_pkg::*;

  logic              run_sw;
  logic              step_btn;
  logic              dir_sw;
  logic              load_sw;
  logic [CODE_W-1:0] load_val;
  logic [CODE_W-1:0] code;
  logic              code_valid;
  logic              wrap;

  modport master (
    output run_sw, step_btn, dir_sw,
    output load_sw, load_val,
    input  code, code_valid, wrap
  );

  modport slave (
    input  run_sw, step_btn, dir_sw,
    input  load_sw, load_val,
    output code, code_valid, wrap
  );

endinterface

// File: rtl/sw_debounce.sv
// Push-button debouncer with a one-cycle pulse on each accepted rise.
// The level moves only after DEBOUNCE_CYCLES consecutive differing samples.
module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk_2,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    if (raw != level_q) begin
      if (cnt_q == LAST) begin
        level_d = raw;
        rise_d  = raw;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_2) begin
    if (!rst_n) begin
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/seg_code_sequencer.sv
// Display code sequencer: load, auto-run on a tick divider, or manual step.
// Code stays in 0..MAX_CODE and flags wraps with a one-cycle pulse.
module seg_code_sequencer
  import seg_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TICK_DIV        = 2
) (
  input  logic              clk_2,
  input  logic              rst_n,
  input  logic              run_sw,
  input  logic              step_btn,
  input  logic              dir_sw,
  input  logic              load_sw,
  input  logic [CODE_W-1:0] load_val,
  output logic [CODE_W-1:0] code,
  output logic              code_valid,
  output logic              wrap
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  seq_state_e        state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic              valid_q, valid_d;
  logic              wrap_q, wrap_d;
  logic              adv;
  logic              step_level;
  logic              step_rise;

  sw_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .clk_2(clk_2),
    .rst_n(rst_n),
    .raw  (step_btn),
    .level(step_level),
    .rise (step_rise)
  );

  always_comb begin
    state_d = HOLD;
    if (load_sw) state_d = LOAD;
    else if (run_sw) state_d = RUN;

    adv    = 1'b0;
    tick_d = '0;
    code_d = code_q;
    wrap_d = 1'b0;
    case (state_q)
      LOAD: code_d = clamp_code(load_val);
      RUN: begin
        if (tick_q == TICK_LAST) adv = 1'b1;
        else tick_d = tick_q + TW'(1);
      end
      HOLD: adv = step_rise & step_level;
      default: ;
    endcase
    if (adv) {wrap_d, code_d} = step_code(code_q, dir_sw);

    // Code written from load_val settles one cycle after LOAD ends.
    valid_d = !(load_sw || (state_q == LOAD));
  end

  always_ff @(posedge clk_2) begin
    if (!rst_n) begin
      state_q <= HOLD;
      code_q  <= '0;
      tick_q  <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      tick_q  <= tick_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign code       = code_q;
  assign code_valid = valid_q;
  assign wrap       = wrap_q;

endmodule

// File: tb/tb_seg_code_sequencer.sv
// Directed bench for seg_code_sequencer.
// Inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_seg_code_sequencer;
  import seg_pkg::*;

  logic clk_2;
  logic rst_n;
  int   checks;
  int   failures;

  seg_code_sequencer_if sif ();

  seg_code_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .TICK_DIV       (2)
  ) dut (
    .clk_2     (clk_2),
    .rst_n     (rst_n),
    .run_sw    (sif.run_sw),
    .step_btn  (sif.step_btn),
    .dir_sw    (sif.dir_sw),
    .load_sw   (sif.load_sw),
    .load_val  (sif.load_val),
    .code      (sif.code),
    .code_valid(sif.code_valid),
    .wrap      (sif.wrap)
  );

  initial clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  task automatic cyc();
    @(posedge clk_2);
    #1;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    sif.run_sw   = 1'b0;
    sif.step_btn = 1'b0;
    sif.dir_sw   = 1'b0;
    sif.load_sw  = 1'b0;
    sif.load_val = '0;
    cyc();
    cyc();
    checks++;
    if (sif.code !== 6'd0) begin
      failures++;
      $display("FAIL reset_code got=%0d exp=0", sif.code);
    end
    checks++;
    if (sif.code_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got=%b exp=0", sif.code_valid);
    end
    checks++;
    if (sif.wrap !== 1'b0) begin
      failures++;
      $display("FAIL reset_wrap got=%b exp=0", sif.wrap);
    end
    checks++;
    if (dut.state_q !== HOLD) begin
      failures++;
      $display("FAIL reset_state got=%0d exp=%0d", dut.state_q, HOLD);
    end
    rst_n = 1'b1;
    cyc();
    checks++;
    if (sif.code_valid !== 1'b1) begin
      failures++;
      $display("FAIL first_valid got=%b exp=1", sif.code_valid);
    end
  endtask

  task automatic test_step_clean();
    logic [5:0] exp;
    sif.step_btn = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      exp = (i >= 5) ? 6'd1 : 6'd0;
      checks++;
      if (sif.code !== exp) begin
        failures++;
        $display("FAIL step_clean e%0d got=%0d exp=%0d", i, sif.code, exp);
      end
      checks++;
      if (sif.wrap !== 1'b0) begin
        failures++;
        $display("FAIL step_clean_wrap e%0d got=%b exp=0", i, sif.wrap);
      end
    end
    sif.step_btn = 1'b0;
    repeat (8) cyc();
    checks++;
    if (sif.code !== 6'd1) begin
      failures++;
      $display("FAIL step_once got=%0d exp=1", sif.code);
    end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 5; i++) begin
      sif.step_btn = (i % 2 == 0);
      cyc();
      checks++;
      if (sif.code !== 6'd1 || sif.wrap !== 1'b0) begin
        failures++;
        $display("FAIL bounce e%0d got=%0d/%b exp=1/0", i, sif.code, sif.wrap);
      end
    end
    sif.step_btn = 1'b0;
    repeat (6) cyc();
    checks++;
    if (sif.code !== 6'd1) begin
      failures++;
      $display("FAIL bounce_settle got=%0d exp=1", sif.code);
    end
  endtask

  task automatic test_load_run();
    int exp_code [6] = '{40, 40, 41, 41, 0, 0};
    int exp_wrap [6] = '{0, 0, 0, 0, 1, 0};
    int exp_val  [6] = '{0, 1, 1, 1, 1, 1};
    sif.load_val = 6'd40;
    sif.load_sw  = 1'b1;
    sif.dir_sw   = 1'b0;
    cyc();
    checks++;
    if (sif.code_valid !== 1'b0) begin
      failures++;
      $display("FAIL load_valid got=%b exp=0", sif.code_valid);
    end
    sif.load_sw = 1'b0;
    sif.run_sw  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) sif.run_sw = 1'b0;
      cyc();
      checks++;
      if (sif.code !== 6'(exp_code[i]) || sif.wrap !== 1'(exp_wrap[i])
          || sif.code_valid !== 1'(exp_val[i])) begin
        failures++;
        $display("FAIL load_run e%0d got=%0d/%b/%b exp=%0d/%0d/%0d",
                 i, sif.code, sif.wrap, sif.code_valid,
                 exp_code[i], exp_wrap[i], exp_val[i]);
      end
    end
    repeat (4) cyc();
    checks++;
    if (sif.code !== 6'd0 || sif.wrap !== 1'b0) begin
      failures++;
      $display("FAIL run_stop got=%0d/%b exp=0/0", sif.code, sif.wrap);
    end
  endtask

  task automatic test_clamp_down();
    sif.load_val = 6'd63;
    sif.load_sw  = 1'b1;
    cyc();
    sif.load_sw = 1'b0;
    cyc();
    checks++;
    if (sif.code !== 6'd41 || sif.code_valid !== 1'b0) begin
      failures++;
      $display("FAIL clamp got=%0d/%b exp=41/0", sif.code, sif.code_valid);
    end
    cyc();
    checks++;
    if (sif.code_valid !== 1'b1) begin
      failures++;
      $display("FAIL clamp_valid got=%b exp=1", sif.code_valid);
    end
    sif.dir_sw   = 1'b1;
    sif.step_btn = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      cyc();
      checks++;
      if (sif.code !== ((i == 5) ? 6'd40 : 6'd41) || sif.wrap !== 1'b0) begin
        failures++;
        $display("FAIL down_step e%0d got=%0d/%b", i, sif.code, sif.wrap);
      end
    end
    sif.step_btn = 1'b0;
    repeat (6) cyc();
    sif.load_val = 6'd0;
    sif.load_sw  = 1'b1;
    cyc();
    sif.load_sw = 1'b0;
    cyc();
    checks++;
    if (sif.code !== 6'd0) begin
      failures++;
      $display("FAIL load_zero got=%0d exp=0", sif.code);
    end
    sif.step_btn = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      checks++;
      if (sif.code !== ((i >= 5) ? 6'd41 : 6'd0)
          || sif.wrap !== (i == 5)) begin
        failures++;
        $display("FAIL down_wrap e%0d got=%0d/%b", i, sif.code, sif.wrap);
      end
    end
    sif.step_btn = 1'b0;
    sif.dir_sw   = 1'b0;
    repeat (6) cyc();
  endtask

  task automatic test_run_step();
    logic [5:0] exp;
    sif.load_val = 6'd10;
    sif.load_sw  = 1'b1;
    cyc();
    sif.load_sw = 1'b0;
    sif.run_sw  = 1'b1;
    cyc();
    checks++;
    if (sif.code !== 6'd10) begin
      failures++;
      $display("FAIL run_step_load got=%0d exp=10", sif.code);
    end
    sif.step_btn = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      exp = 6'(10 + k / 2);
      checks++;
      if (sif.code !== exp) begin
        failures++;
        $display("FAIL run_step k%0d got=%0d exp=%0d", k, sif.code, exp);
      end
    end
    sif.run_sw = 1'b0;
    cyc();
    sif.step_btn = 1'b0;
    repeat (6) cyc();
    checks++;
    if (sif.code !== 6'd14) begin
      failures++;
      $display("FAIL run_step_end got=%0d exp=14", sif.code);
    end
  endtask

  task automatic test_reset_mid();
    sif.load_val = 6'd17;
    sif.load_sw  = 1'b1;
    cyc();
    sif.load_sw = 1'b0;
    sif.run_sw  = 1'b1;
    cyc();
    checks++;
    if (sif.code !== 6'd17 || dut.state_q !== RUN) begin
      failures++;
      $display("FAIL mid_pre got=%0d/%0d exp=17/%0d",
               sif.code, dut.state_q, RUN);
    end
    cyc();
    rst_n        = 1'b0;
    sif.load_sw  = 1'b1;
    sif.step_btn = 1'b1;
    cyc();
    checks++;
    if (sif.code !== 6'd0 || sif.code_valid !== 1'b0 || sif.wrap !== 1'b0
        || dut.state_q !== HOLD) begin
      failures++;
      $display("FAIL mid_reset got=%0d/%b/%b/%0d exp=0/0/0/%0d",
               sif.code, sif.code_valid, sif.wrap, dut.state_q, HOLD);
    end
    rst_n        = 1'b1;
    sif.load_sw  = 1'b0;
    sif.run_sw   = 1'b0;
    sif.step_btn = 1'b0;
    cyc();
    checks++;
    if (sif.code_valid !== 1'b1 || sif.code !== 6'd0) begin
      failures++;
      $display("FAIL mid_release got=%0d/%b exp=0/1",
               sif.code, sif.code_valid);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_step_clean();
    test_bounce();
    test_load_run();
    test_clamp_down();
    test_run_step();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
